// File: rtl/sd_sboard_pkg.sv
// sd_sboard_pkg: request codes, requester id type and arbiter FSM states shared by the scoreboard arbiter
package sd_sboard_pkg;
   localparam logic REQ_READ  = 1'b0;
   localparam logic REQ_WRITE = 1'b1;
   typedef logic req_id_t;
   typedef enum logic {IDLE, HOLD} arb_state_t;
endpackage

// File: rtl/sd_sboard_arb_if.sv
// sd_sboard_arb_if: two requester ports, scoreboard request port and scoreboard response port
interface sd_sboard_arb_if #(
   parameter int width = 64,
   parameter int s_asz = 13
);
   logic             r0_srdy, r1_srdy, r0_drdy, r1_drdy, r0_req_type, r1_req_type;
   logic [s_asz-1:0] r0_itemid, r1_itemid;
   logic [width-1:0] r0_mask, r1_mask, r0_data, r1_data;
   logic             r0p_srdy, r1p_srdy, r0p_drdy, r1p_drdy;
   logic [width-1:0] r0p_data, r1p_data;
   logic             c_srdy, c_drdy, c_req_type, c_txid;
   logic [s_asz-1:0] c_itemid;
   logic [width-1:0] c_mask, c_data;
   logic             p_srdy, p_drdy, p_txid;
   logic [width-1:0] p_data;
   modport slave (
      input  r0_srdy, r1_srdy, r0_req_type, r1_req_type, r0_itemid, r1_itemid,
             r0_mask, r1_mask, r0_data, r1_data, r0p_drdy, r1p_drdy,
             c_drdy, p_srdy, p_txid, p_data,
      output r0_drdy, r1_drdy, r0p_srdy, r1p_srdy, r0p_data, r1p_data,
             c_srdy, c_req_type, c_txid, c_itemid, c_mask, c_data, p_drdy
   );
   modport master (
      output r0_srdy, r1_srdy, r0_req_type, r1_req_type, r0_itemid, r1_itemid,
             r0_mask, r1_mask, r0_data, r1_data, r0p_drdy, r1p_drdy,
             c_drdy, p_srdy, p_txid, p_data,
      input  r0_drdy, r1_drdy, r0p_srdy, r1p_srdy, r0p_data, r1p_data,
             c_srdy, c_req_type, c_txid, c_itemid, c_mask, c_data, p_drdy
   );
endinterface

// File: rtl/sd_sboard_tagq.sv
// sd_sboard_tagq: in-order FIFO of requester ids for outstanding reads, with wrap bit for full/empty
module sd_sboard_tagq
   import sd_sboard_pkg::*;
#(
   parameter int depth = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  logic    pop,
   input  req_id_t din,
   output req_id_t dout,
   output logic    full,
   output logic    empty
);
   localparam int aw = $clog2(depth);
   logic [aw:0] wp, rp;
   req_id_t mem [depth];
   assign empty = wp == rp;
   assign full  = (wp[aw] != rp[aw]) && (wp[aw-1:0] == rp[aw-1:0]);
   assign dout  = mem[rp[aw-1:0]];
   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end
   end
   always_ff @(posedge clk) if (push) mem[wp[aw-1:0]] <= din;
endmodule

// File: rtl/sd_sboard_arb.sv
// sd_sboard_arb: round-robin merge of two requesters onto one scoreboard port with read-response routing; SD_SBOARD_ARB_TXID_EN routes by p_txid instead of the tag queue
module sd_sboard_arb
   import sd_sboard_pkg::*;
#(
   parameter int tag_depth = 4
) (
   input  logic           clk,
   input  logic           reset,
   sd_sboard_arb_if.slave bus
);
   arb_state_t state, nxt_state;
   req_id_t prio, held, gnt, dest;
   logic gnt_v, acc, q_full, route_v, elig0, elig1, pe, oe;
   assign elig0 = bus.r0_srdy & ((bus.r0_req_type == REQ_WRITE) | !q_full);
   assign elig1 = bus.r1_srdy & ((bus.r1_req_type == REQ_WRITE) | !q_full);
   assign pe = prio ? elig1 : elig0;
   assign oe = prio ? elig0 : elig1;
   // a held grant is re-presented as-is so the request stays stable until taken
   always_comb begin
      gnt = (state == HOLD) ? held : (pe ? prio : ~prio);
      gnt_v = !reset & ((state == HOLD) | pe | oe);
      nxt_state = (gnt_v & !bus.c_drdy) ? HOLD : IDLE;
   end
   assign acc            = gnt_v & bus.c_drdy;
   assign bus.c_srdy     = gnt_v;
   assign bus.c_req_type = gnt_v & (gnt ? bus.r1_req_type : bus.r0_req_type);
   assign bus.c_itemid   = !gnt_v ? '0 : gnt ? bus.r1_itemid : bus.r0_itemid;
   assign bus.c_mask     = !gnt_v ? '0 : gnt ? bus.r1_mask : bus.r0_mask;
   assign bus.c_data     = !gnt_v ? '0 : gnt ? bus.r1_data : bus.r0_data;
   assign bus.r0_drdy    = acc & !gnt;
   assign bus.r1_drdy    = acc & gnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         prio  <= 1'b0;
         held  <= 1'b0;
      end else begin
         state <= nxt_state;
         held  <= gnt;
         if (acc) prio <= ~gnt;
      end
   end
`ifdef SD_SBOARD_ARB_TXID_EN
   assign q_full     = 1'b0;
   assign dest       = bus.p_txid;
   assign route_v    = !reset;
   assign bus.c_txid = gnt_v & gnt;
`else
   logic q_empty, push, pop;
   req_id_t q_head;
   assign push       = acc & (bus.c_req_type == REQ_READ);
   assign pop        = bus.p_srdy & bus.p_drdy;
   assign dest       = q_head;
   assign route_v    = !reset & !q_empty;
   assign bus.c_txid = 1'b0;
   sd_sboard_tagq #(.depth(tag_depth)) u_tagq (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(gnt),
      .dout(q_head), .full(q_full), .empty(q_empty)
   );
   always_ff @(posedge clk)
      if (!reset) assert (!(bus.p_srdy & q_empty)) else $error("sd_sboard_arb: response with no outstanding read");
`endif
   assign bus.p_drdy   = route_v & (dest ? bus.r1p_drdy : bus.r0p_drdy);
   assign bus.r0p_srdy = route_v & !dest & bus.p_srdy;
   assign bus.r1p_srdy = route_v & dest & bus.p_srdy;
   assign bus.r0p_data = (route_v & !dest) ? bus.p_data : '0;
   assign bus.r1p_data = (route_v & dest) ? bus.p_data : '0;
endmodule

// File: tb/tb_sd_sboard_arb.sv
// tb_sd_sboard_arb: directed checks of grant order, hold, tag-queue limit, response routing and reset
module tb_sd_sboard_arb;
   import sd_sboard_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_tests = 0;
   int n_fail = 0;
   sd_sboard_arb_if #(.width(64), .s_asz(13)) bus ();
   sd_sboard_arb #(.tag_depth(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_tests++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic idle;
      bus.r0_srdy = 0; bus.r0_req_type = 0; bus.r0_itemid = 0; bus.r0_mask = 0; bus.r0_data = 0;
      bus.r1_srdy = 0; bus.r1_req_type = 0; bus.r1_itemid = 0; bus.r1_mask = 0; bus.r1_data = 0;
      bus.r0p_drdy = 0; bus.r1p_drdy = 0; bus.c_drdy = 0;
      bus.p_srdy = 0; bus.p_txid = 0; bus.p_data = 0;
   endtask
   task automatic req(input int n, input logic t, input logic [12:0] id, input logic [63:0] d);
      if (n == 0) begin
         bus.r0_srdy = 1; bus.r0_req_type = t; bus.r0_itemid = id; bus.r0_mask = '1; bus.r0_data = d;
      end else begin
         bus.r1_srdy = 1; bus.r1_req_type = t; bus.r1_itemid = id; bus.r1_mask = '1; bus.r1_data = d;
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      idle();
      cyc(); cyc();
      reset = 0;
      #1;
      chk("rst_c_srdy", bus.c_srdy, 0);
      chk("rst_state", dut.state, IDLE);
      chk("rst_prio", dut.prio, 0);
      chk("rst_q_empty", dut.q_empty, 1);
      chk("rst_p_drdy", bus.p_drdy, 0);
      // single write from r0
      req(0, REQ_WRITE, 5, 64'h1122334455667788);
      bus.c_drdy = 1;
      #1;
      chk("wr_c_srdy", bus.c_srdy, 1);
      chk("wr_r0_drdy", bus.r0_drdy, 1);
      chk("wr_r1_drdy", bus.r1_drdy, 0);
      chk("wr_type", bus.c_req_type, 1);
      chk("wr_item", bus.c_itemid, 5);
      chk("wr_mask", bus.c_mask, 64'hffff_ffff_ffff_ffff);
      chk("wr_data", bus.c_data, 64'h1122334455667788);
      chk("wr_txid", bus.c_txid, 0);
      cyc();
      idle();
      #1;
      chk("wr_no_rsp0", bus.r0p_srdy, 0);
      chk("wr_no_rsp1", bus.r1p_srdy, 0);
      chk("wr_q_empty", dut.q_empty, 1);
      chk("wr_prio", dut.prio, 1);
      // r1 write returns priority to r0
      req(1, REQ_WRITE, 7, 64'h7);
      bus.c_drdy = 1;
      #1;
      chk("w1_item", bus.c_itemid, 7);
      chk("w1_r1_drdy", bus.r1_drdy, 1);
      cyc();
      idle();
      // round robin reads
      req(0, REQ_READ, 10, 0);
      req(1, REQ_READ, 20, 0);
      bus.c_drdy = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_item", bus.c_itemid, (i % 2) ? 20 : 10);
         chk("rr_r0_drdy", bus.r0_drdy, (i % 2) == 0);
         chk("rr_r1_drdy", bus.r1_drdy, (i % 2) == 1);
         cyc();
      end
      idle();
      bus.p_srdy = 1; bus.r0p_drdy = 1; bus.r1p_drdy = 1;
      for (int i = 0; i < 4; i++) begin
         bus.p_data = 64'hA0 + 64'(i);
         #1;
         chk("rsp_r0p_srdy", bus.r0p_srdy, (i % 2) == 0);
         chk("rsp_r1p_srdy", bus.r1p_srdy, (i % 2) == 1);
         chk("rsp_data", (i % 2) ? bus.r1p_data : bus.r0p_data, 64'hA0 + 64'(i));
         chk("rsp_p_drdy", bus.p_drdy, 1);
         cyc();
      end
      idle();
      #1;
      chk("rsp_q_empty", dut.q_empty, 1);
      // r1 held while r0 has priority
      req(1, REQ_READ, 33, 0);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) req(0, REQ_WRITE, 44, 64'h44);
         #1;
         chk("hold_item", bus.c_itemid, 33);
         chk("hold_r0_drdy", bus.r0_drdy, 0);
         chk("hold_state", dut.state, (i == 0) ? IDLE : HOLD);
         cyc();
      end
      bus.c_drdy = 1;
      #1;
      chk("hold_rel_item", bus.c_itemid, 33);
      chk("hold_rel_r1_drdy", bus.r1_drdy, 1);
      chk("hold_rel_r0_drdy", bus.r0_drdy, 0);
      cyc();
      bus.r1_srdy = 0;
      #1;
      chk("hold_next_item", bus.c_itemid, 44);
      chk("hold_next_r0_drdy", bus.r0_drdy, 1);
      cyc();
      idle();
      bus.p_srdy = 1; bus.p_data = 64'hC0C0; bus.r1p_drdy = 1;
      #1;
      chk("hold_rsp_r1p", bus.r1p_srdy, 1);
      chk("hold_rsp_r0p", bus.r0p_srdy, 0);
      chk("hold_rsp_data", bus.r1p_data, 64'hC0C0);
      cyc();
      idle();
      // tag queue full
      req(0, REQ_READ, 50, 0);
      bus.c_drdy = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("fill_r0_drdy", bus.r0_drdy, 1);
         cyc();
      end
      #1;
      chk("full_flag", dut.q_full, 1);
      chk("full_c_srdy", bus.c_srdy, 0);
      req(1, REQ_WRITE, 60, 64'h66);
      #1;
      chk("full_wr_item", bus.c_itemid, 60);
      chk("full_wr_r1_drdy", bus.r1_drdy, 1);
      chk("full_rd_r0_drdy", bus.r0_drdy, 0);
      cyc();
      bus.r1_srdy = 0;
      bus.p_srdy = 1; bus.p_data = 64'hD0D0; bus.r0p_drdy = 1;
      #1;
      chk("full_pop_c_srdy", bus.c_srdy, 0);
      chk("full_pop_r0p", bus.r0p_srdy, 1);
      chk("full_pop_p_drdy", bus.p_drdy, 1);
      cyc();
      bus.p_srdy = 0;
      #1;
      chk("after_pop_c_srdy", bus.c_srdy, 1);
      chk("after_pop_item", bus.c_itemid, 50);
      chk("after_pop_r0_drdy", bus.r0_drdy, 1);
      cyc();
      idle();
      #1;
      chk("refill_full", dut.q_full, 1);
      // response back-pressured by r0p_drdy
      bus.p_srdy = 1; bus.p_data = 64'hE0E0; bus.r1p_drdy = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("bp_p_drdy", bus.p_drdy, 0);
         chk("bp_r1p", bus.r1p_srdy, 0);
         chk("bp_r0p", bus.r0p_srdy, 1);
         chk("bp_data", bus.r0p_data, 64'hE0E0);
         cyc();
      end
      bus.r0p_drdy = 1;
      #1;
      chk("bp_rel_p_drdy", bus.p_drdy, 1);
      chk("bp_rel_nopop", dut.q_full, 1);
      cyc();
      idle();
      #1;
      chk("bp_popped", dut.q_full, 0);
      // reset with reads outstanding and FSM in HOLD
      bus.p_srdy = 1; bus.r0p_drdy = 1;
      cyc();
      idle();
      req(1, REQ_WRITE, 70, 0);
      cyc();
      chk("pre_rst_state", dut.state, HOLD);
      chk("pre_rst_q_empty", dut.q_empty, 0);
      reset = 1;
      #1;
      chk("in_rst_c_srdy", bus.c_srdy, 0);
      chk("in_rst_r1_drdy", bus.r1_drdy, 0);
      chk("in_rst_item", bus.c_itemid, 0);
      cyc();
      reset = 0;
      idle();
      bus.p_data = 64'hDEAD;
      #1;
      chk("post_rst_state", dut.state, IDLE);
      chk("post_rst_q_empty", dut.q_empty, 1);
      chk("post_rst_prio", dut.prio, 0);
      chk("post_rst_c_srdy", bus.c_srdy, 0);
      chk("post_rst_p_drdy", bus.p_drdy, 0);
      chk("post_rst_r0p_data", bus.r0p_data, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sd_sboard_arb.md
# sd_sboard_arb

Two-requester arbiter in front of the `sd_scoreboard` consumer/producer ports. It lets the Z80-side `sd_access64` path (requester 0) and a second master, such as a DMA or video fetch engine (requester 1), share one scoreboard instance. Requests are merged round-robin, and read responses are routed back to the requester that issued them. The block sits between the access engines and `sboard` inside the memory wrapper.

## Interface
- `width`, 64, data/mask width
- `s_asz`, 13, item-id width ($clog2 of scoreboard items)
- `tag_depth`, 4, max outstanding reads (power of 2, ≥2)
- `clk` input 1, clock
- `reset` input 1, synchronous, active-high
- `r0_srdy`/`r1_srdy` input 1, request valid
- `r0_drdy`/`r1_drdy` output 1, request accepted
- `r0_req_type`/`r1_req_type` input 1, 0 = read, 1 = write
- `r0_itemid`/`r1_itemid` input s_asz, item address
- `r0_mask`/`r1_mask` input width, write mask
- `r0_data`/`r1_data` input width, write data
- `r0p_srdy`/`r1p_srdy` output 1, read response valid
- `r0p_drdy`/`r1p_drdy` input 1, response taken
- `r0p_data`/`r1p_data` output width, read data
- `c_srdy` output 1; `c_drdy` input 1; `c_req_type` output 1; `c_itemid` output s_asz; `c_mask`, `c_data` output width: scoreboard request port
- `c_txid` output 1, requester id (0 when TXID feature off)
- `p_srdy` input 1; `p_drdy` output 1; `p_txid` input 1; `p_data` input width: scoreboard response port

## Operation
- Eligibility: requester n is eligible when rn_srdy=1, and for reads only, the tag queue is not full.
- FSM states: IDLE and HOLD.
- IDLE, grant selection:
  - The eligible requester with priority wins; otherwise the other eligible requester wins.
  - The winner's fields drive the c_* outputs combinationally, with c_srdy=1.
  - rn_drdy = c_drdy for the winner, 0 for the loser.
  - If c_drdy=1: the transfer completes, priority moves to the other requester, and the FSM stays in IDLE.
  - If c_drdy=0: the grant is latched and the FSM goes to HOLD.
- HOLD:
  - The latched requester is presented unconditionally, even if its read has become ineligible, because srdy/drdy requires a stable request.
  - On c_drdy=1: priority rotates away from the latched requester and the FSM returns to IDLE.
  - The other requester waits regardless of its srdy.
- Every accepted read pushes its requester id into the tag queue. Writes push nothing and produce no response.
- Response routing:
  - The queue head selects the destination: rhp_srdy = p_srdy, p_drdy = rhp_drdy, data passes through.
  - The non-selected rp_srdy = 0.
  - A pop happens on p_srdy & p_drdy.
- Simultaneous push and pop in one cycle are both honoured; occupancy is unchanged.
- Queue full: reads from both requesters are ineligible and writes still flow. A full queue never drops a response.
- p_srdy with an empty queue is a protocol error: p_drdy=0, nothing routed, and a simulation-only assertion fires.
- Reset mid-transaction: FSM to IDLE, priority to r0, queue emptied, and outstanding responses are discarded. The scoreboard must be reset in the same cycle.

## Timing
- Reset values:
  - c_srdy=0, c_req_type=0, c_txid=0, c_itemid/c_mask/c_data=0
  - p_drdy=0, all rn_drdy=0, all rnp_srdy=0, rnp_data=0
  - FSM=IDLE, priority=r0
- Request path is zero-latency combinational in IDLE. A grant taken in cycle t with c_drdy=1 completes in cycle t.
- Response path is zero-latency combinational pass-through.
- The priority register updates on the clock edge after acceptance. Back-to-back grants alternate when both requesters are continuously eligible.
- Queue pointers wrap modulo tag_depth. A full/empty distinction bit is kept.

## Configuration
- `SD_SBOARD_ARB_TXID_EN` defined:
  - c_txid = granted requester id.
  - Responses are routed by p_txid; the tag queue is not built.
  - There is no outstanding-read limit, and reads are always eligible when srdy=1.
  - The scoreboard is instantiated with use_txid=1.
- Undefined:
  - c_txid tied to 0 and p_txid ignored.
  - In-order routing via the tag queue with limit tag_depth.

## Structure
- `sd_sboard_pkg` holds:
  - `REQ_READ`=1'b0, `REQ_WRITE`=1'b1
  - typedef `req_id_t` (1 bit)
  - FSM state enum `arb_state_t` {IDLE, HOLD}
- Sub-module `sd_sboard_tagq`: small synchronous FIFO of req_id_t, depth tag_depth, with push/pop/full/empty. It is omitted under SD_SBOARD_ARB_TXID_EN.

## Test plan
- After reset, r0 write to item 5 (mask all-ones, data 0x1122334455667788) with c_drdy=1: c_srdy and r0_drdy high the same cycle, no response on either port.
- Both requesters assert reads continuously with c_drdy=1: grants go r0, r1, r0, r1. Responses returned in order land on r0p, r1p, r0p, r1p with matching data.
- r1 granted with c_drdy=0 for 3 cycles while r0 has priority and asserts srdy: c_itemid stays r1's value throughout, r0_drdy=0, r0 is granted in the cycle after r1 is accepted.
- tag_depth=4, four reads outstanding with p_srdy held 0: a fifth read is not granted while a write from the other requester is. After one response pops, the read is accepted the next cycle.
- A response to r0 is held by r0p_drdy=0 for 2 cycles: p_drdy=0, r1p_srdy=0, the data is stable, and the pop occurs on the release cycle.
- reset asserted with 2 reads outstanding and FSM in HOLD: the next cycle shows IDLE, an empty queue, all outputs at reset values, and priority r0.
